mode_ctrl: RTL

MODE_CTRL -- requirements
Module: mode_ctrl

---
 rtl/mode_ctrl_if.sv | 33 +++
 rtl/mode_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// mode_ctrl_if -- button inputs, display sources and mode/status outputs of
//                 the watch mode controller.
// Revision: 1.0
// ============================================================================
interface mode_ctrl_if;
  logic        b1;
  logic        b2;
  logic        b3;
  logic [15:0] clk_bcd;
  logic [15:0] alarm_bcd;
  logic [15:0] sw_bcd;
  logic [3:0]  state1;
  logic        app_b1;
  logic        app_b2;
  logic        inc_pulse;
  logic        set_field;
  logic        alarm_en;
  logic [15:0] disp_bcd;
  logic [3:0]  blank;

  modport slave (
    input  b1, b2, b3, clk_bcd, alarm_bcd, sw_bcd,
    output state1, app_b1, app_b2, inc_pulse, set_field, alarm_en, disp_bcd, blank
  );

  modport master (
    output b1, b2, b3, clk_bcd, alarm_bcd, sw_bcd,
    input  state1, app_b1, app_b2, inc_pulse, set_field, alarm_en, disp_bcd, blank
  );
endinterface
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
// mode_ctrl -- debounced three-button mode controller for a clock/alarm/
//              stopwatch watch: mode FSM, set-mode timeout, blink and display mux.
// Revision: 1.0
// ============================================================================
module mode_ctrl #(
  parameter int DEB_CYC    = 20,
  parameter int BLINK_HALF = 500,
  parameter int TIMEOUT    = 30000
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mode_ctrl_if.slave  bus
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int BLK_W = $clog2(2 * BLINK_HALF);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(2 * BLINK_HALF - 1);
  localparam logic [BLK_W-1:0] BLINK_MID  = BLK_W'(BLINK_HALF);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    MODE_CLOCK     = 4'd0,
    MODE_CLK_SET   = 4'd1,
    MODE_ALARM     = 4'd2,
    MODE_AL_SET    = 4'd3,
    MODE_STOPWATCH = 4'd4
  } mode_e;

  logic [2:0] btn_raw;
  logic [2:0] press_q;

  assign btn_raw = {bus.b3, bus.b2, bus.b1};

  // Debounced level restarts high so a button held through reset must be
  // released before its next rising edge can produce a press.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             level_q;
      logic             pulse_q;
      logic [DEB_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          level_q <= 1'b1;
          pulse_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= btn_raw[i];
          sync2_q <= sync1_q;
          pulse_q <= 1'b0;
          if (sync2_q == level_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
            pulse_q <= sync2_q;
          end else begin
            cnt_q <= cnt_q + DEB_W'(1);
          end
        end
      end

      assign press_q[i] = pulse_q;
    end
  endgenerate

  logic p1;
  logic p2;
  logic p3;
  logic any_press;

  assign p3        = press_q[2];
  assign p2        = press_q[1] & ~press_q[2];
  assign p1        = press_q[0] & ~press_q[1] & ~press_q[2];
  assign any_press = |press_q;

  mode_e            state_q, state_d;
  logic             set_field_q, set_field_d;
  logic             alarm_en_q, alarm_en_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  logic [15:0]      disp_q, disp_d;
  logic             in_set;
  logic             fwd_b1;
  logic             fwd_b2;
  logic             inc_req;
  logic [3:0]       blank_mask;

  assign in_set = (state_q == MODE_CLK_SET) || (state_q == MODE_AL_SET);

  always_comb begin
    state_d     = state_q;
    set_field_d = set_field_q;
    alarm_en_d  = alarm_en_q;
    fwd_b1      = 1'b0;
    fwd_b2      = 1'b0;
    inc_req     = 1'b0;
    to_d        = in_set ? (to_q + TO_W'(1)) : '0;
    blink_d     = (in_set && (blink_q != BLINK_LAST)) ? (blink_q + BLK_W'(1)) : '0;

    case (state_q)
      MODE_CLOCK: begin
        if (p3) begin
          state_d = MODE_ALARM;
        end else if (p2) begin
          state_d     = MODE_CLK_SET;
          set_field_d = 1'b0;
          to_d        = '0;
          blink_d     = '0;
        end
      end
      MODE_ALARM: begin
        if (p3) begin
          state_d = MODE_STOPWATCH;
        end else if (p2) begin
          state_d     = MODE_AL_SET;
          set_field_d = 1'b0;
          to_d        = '0;
          blink_d     = '0;
        end else if (p1) begin
          alarm_en_d = ~alarm_en_q;
        end
      end
      MODE_CLK_SET, MODE_AL_SET: begin
        if (p3) begin
          state_d = (state_q == MODE_CLK_SET) ? MODE_CLOCK : MODE_ALARM;
        end else if (p2) begin
          set_field_d = ~set_field_q;
          blink_d     = '0;
        end else if (p1) begin
          inc_req = 1'b1;
        end else if (to_q == TO_LAST) begin
          state_d = (state_q == MODE_CLK_SET) ? MODE_CLOCK : MODE_ALARM;
        end
      end
      MODE_STOPWATCH: begin
        if (p3) begin
          state_d = MODE_CLOCK;
        end else begin
          fwd_b1 = p1;
          fwd_b2 = p2;
        end
      end
      default: begin
        state_d = MODE_CLOCK;
      end
    endcase

    if (any_press) begin
      to_d = '0;
    end

    case (state_q)
      MODE_ALARM, MODE_AL_SET: disp_d = bus.alarm_bcd;
      MODE_STOPWATCH:          disp_d = bus.sw_bcd;
      default:                 disp_d = bus.clk_bcd;
    endcase

    // Hours occupy d3,d2 and minutes d1,d0; the field being set blinks.
    blank_mask = 4'b0000;
    if (in_set && (blink_q >= BLINK_MID)) begin
      blank_mask = set_field_q ? 4'b0011 : 4'b1100;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MODE_CLOCK;
      set_field_q <= 1'b0;
      alarm_en_q  <= 1'b0;
      to_q        <= '0;
      blink_q     <= '0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      set_field_q <= set_field_d;
      alarm_en_q  <= alarm_en_d;
      to_q        <= to_d;
      blink_q     <= blink_d;
      disp_q      <= disp_d;
    end
  end

  assign bus.state1    = state_q;
  assign bus.app_b1    = fwd_b1;
  assign bus.app_b2    = fwd_b2;
  assign bus.inc_pulse = inc_req;
  assign bus.set_field = set_field_q;
  assign bus.alarm_en  = alarm_en_q;
  assign bus.disp_bcd  = disp_q;
  assign bus.blank     = blank_mask;

endmodule
`default_nettype wire
